// File: rtl/mips_alu_if.sv
// mips_alu_if: operand/result bundle for the MIPS ALU.
//   SrcA, SrcB, ALUControl         - operands and operation select (driven by master)
//   ALUResult, zero_flag, overflow - combinational ALU outputs
//   result_q, zero_q, ovf_sticky   - registered status outputs
// Modports: master (datapath/bench side), slave (ALU side).
interface mips_alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] ALUResult;
  logic             zero_flag;
  logic             overflow;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_sticky;

  modport master (
    output SrcA, SrcB, ALUControl,
    input  ALUResult, zero_flag, overflow, result_q, zero_q, ovf_sticky
  );

  modport slave (
    input  SrcA, SrcB, ALUControl,
    output ALUResult, zero_flag, overflow, result_q, zero_q, ovf_sticky
  );
endinterface

// File: rtl/mips_alu.sv
// mips_alu: 32-bit integer ALU for a single-cycle MIPS datapath.
// Ports:
//   clk    - rising-edge clock for the registered status stage
//   reset  - synchronous, active-high; clears result_q, zero_q, ovf_sticky
//   alu    - mips_alu_if.slave: SrcA/SrcB/ALUControl in; combinational
//            ALUResult/zero_flag/overflow out; registered result_q/zero_q
//            and sticky overflow flag ovf_sticky out.
// Opcodes: 000 AND, 001 OR, 010 ADD, 011 reserved (0), 100 SUB,
//          101 MUL (low bits), 110 SLT (signed), 111 NOR.
// Build option: define ALU_MULT_EN to include the multiplier for opcode 101;
// without it 101 behaves like the reserved opcode and no multiplier exists.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  mips_alu_if.slave alu
);

  // Signed overflow of a + b: same operand signs, result sign differs.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow of a - b: operand signs differ, result sign differs from a.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [WIDTH-1:0] sum;
  logic        [WIDTH-1:0] diff;
  logic                    slt;
  logic        [WIDTH-1:0] result_p0;
  logic                    ovf_p0;

  // Stage p0: combinational ALU, visible in the same cycle.
  assign a_s  = alu.SrcA;
  assign b_s  = alu.SrcB;
  assign sum  = alu.SrcA + alu.SrcB;
  assign diff = alu.SrcA - alu.SrcB;
  // Direct signed compare, so SLT stays correct when SrcA - SrcB overflows.
  assign slt  = (a_s < b_s);

  always_comb begin
    result_p0 = '0;
    ovf_p0    = 1'b0;
    case (alu.ALUControl)
      3'b000: result_p0 = alu.SrcA & alu.SrcB;
      3'b001: result_p0 = alu.SrcA | alu.SrcB;
      3'b010: begin
        result_p0 = sum;
        ovf_p0    = add_ovf(alu.SrcA[WIDTH-1], alu.SrcB[WIDTH-1], sum[WIDTH-1]);
      end
      3'b100: begin
        result_p0 = diff;
        ovf_p0    = sub_ovf(alu.SrcA[WIDTH-1], alu.SrcB[WIDTH-1], diff[WIDTH-1]);
      end
`ifdef ALU_MULT_EN
      3'b101: result_p0 = alu.SrcA * alu.SrcB;
`else
      3'b101: result_p0 = '0;
`endif
      3'b110: result_p0 = {{(WIDTH-1){1'b0}}, slt};
      3'b111: result_p0 = ~(alu.SrcA | alu.SrcB);
      default: result_p0 = '0;
    endcase
  end

  assign alu.ALUResult = result_p0;
  assign alu.zero_flag = (result_p0 == '0);
  assign alu.overflow  = ovf_p0;

  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             ovf_sticky_p1;

  // Stage p1: registered status capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_p1     <= '0;
      zero_p1       <= 1'b0;
      ovf_sticky_p1 <= 1'b0;
    end else begin
      result_p1     <= result_p0;
      zero_p1       <= alu.zero_flag;
      ovf_sticky_p1 <= ovf_sticky_p1 | ovf_p0;
    end
  end

  assign alu.result_q   = result_p1;
  assign alu.zero_q     = zero_p1;
  assign alu.ovf_sticky = ovf_sticky_p1;

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: scoreboard bench for mips_alu. The driver applies one
// directed vector per cycle just after the rising edge and queues the
// hand-computed combinational results together with the registered values
// expected at that point; a monitor pops and compares on the falling edge.
module tb_mips_alu;

  logic clk;
  logic reset;

  mips_alu_if #(.WIDTH(32)) bus ();

  mips_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .alu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic        ovf;
    logic [31:0] rq;
    logic        zq;
    logic        st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Registered-stage model, built from the hand-computed expectations.
  logic [31:0] m_rq;
  logic        m_zq;
  logic        m_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".ALUResult"},  bus.ALUResult,          e.res);
      check({e.name, ".zero_flag"},  {31'b0, bus.zero_flag}, {31'b0, e.z});
      check({e.name, ".overflow"},   {31'b0, bus.overflow},  {31'b0, e.ovf});
      check({e.name, ".result_q"},   bus.result_q,           e.rq);
      check({e.name, ".zero_q"},     {31'b0, bus.zero_q},    {31'b0, e.zq});
      check({e.name, ".ovf_sticky"}, {31'b0, bus.ovf_sticky},{31'b0, e.st});
    end
  end

  // Drive one vector and queue its expectation.
  task automatic vec(input string name, input logic [2:0] ctl, input logic [31:0] a,
                     input logic [31:0] b, input logic rst, input logic [31:0] res,
                     input logic z, input logic ovf);
    exp_t e;
    @(posedge clk);
    #1;
    bus.ALUControl = ctl;
    bus.SrcA       = a;
    bus.SrcB       = b;
    reset          = rst;
    e.name = name; e.res = res; e.z = z; e.ovf = ovf;
    e.rq = m_rq; e.zq = m_zq; e.st = m_st;
    sb.push_back(e);
    if (rst) begin
      m_rq = '0; m_zq = 1'b0; m_st = 1'b0;
    end else begin
      m_rq = res; m_zq = z; m_st = m_st | ovf;
    end
  endtask

  logic [31:0] mul_res;
  logic        mul_z;

  initial begin
`ifdef ALU_MULT_EN
    mul_res = 32'h0003_0D3F; mul_z = 1'b0;
`else
    mul_res = 32'h0000_0000; mul_z = 1'b1;
`endif
    m_rq = '0; m_zq = 1'b0; m_st = 1'b0;
    reset = 1'b1;
    bus.ALUControl = 3'b000;
    bus.SrcA = '0;
    bus.SrcB = '0;
    repeat (2) @(posedge clk);

    //   name       ctl     SrcA          SrcB          rst   ALUResult     z     ovf
    vec("rst0",   3'b000, 32'h0,         32'h0,         1'b1, 32'h0,        1'b1, 1'b0);
    vec("mul0",   3'b101, 32'h0,         32'h0003_0D3F, 1'b0, 32'h0,        1'b1, 1'b0);
    vec("or",     3'b001, 32'h0,         32'h0003_0D3F, 1'b0, 32'h0003_0D3F,1'b0, 1'b0);
    vec("add",    3'b010, 32'h0,         32'h0003_0D3F, 1'b0, 32'h0003_0D3F,1'b0, 1'b0);
    vec("sub",    3'b100, 32'h0,         32'h0003_0D3F, 1'b0, 32'hFFFC_F2C1,1'b0, 1'b0);
    vec("slt",    3'b110, 32'h0,         32'h0003_0D3F, 1'b0, 32'h1,        1'b0, 1'b0);
    vec("nor",    3'b111, 32'h0,         32'h0003_0D3F, 1'b0, 32'hFFFC_F2C0,1'b0, 1'b0);
    vec("and",    3'b000, 32'h0,         32'h0003_0D3F, 1'b0, 32'h0,        1'b1, 1'b0);
    vec("mul1",   3'b101, 32'h1,         32'h0003_0D3F, 1'b0, mul_res,      mul_z,1'b0);
    vec("addovf", 3'b010, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000,1'b0, 1'b1);
    vec("orzero", 3'b001, 32'h0,         32'h0,         1'b0, 32'h0,        1'b1, 1'b0);
    vec("sltmin", 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h1,        1'b0, 1'b0);
    vec("subovf", 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h1,        1'b0, 1'b1);
    vec("rsvd",   3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'h0,        1'b1, 1'b0);
    vec("rstmid", 3'b010, 32'h5,         32'h3,         1'b1, 32'h8,        1'b0, 1'b0);
    vec("norall", 3'b111, 32'h0,         32'h0,         1'b0, 32'hFFFF_FFFF,1'b0, 1'b0);
    vec("rsvd2",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b1, 1'b0);
    vec("and0",   3'b000, 32'h0,         32'h0,         1'b0, 32'h0,        1'b1, 1'b0);
    vec("addwrap",3'b010, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0,        1'b1, 1'b0);
    vec("subovf2",3'b100, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000,1'b0, 1'b1);
    vec("sltmax", 3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'h0,        1'b1, 1'b0);
    vec("andmix", 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'h00F0_00F0,1'b0, 1'b0);
    vec("flush",  3'b000, 32'h0,         32'h0,         1'b0, 32'h0,        1'b1, 1'b0);

    begin : drain
      int n;
      n = 0;
      while (sb.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      if (sb.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
32-bit integer ALU for the single-cycle MIPS datapath, driven by the 3-bit ALUControl from the ALU decoder.
- Combinational result and zero flag feed branch compare and the writeback/memory-address path in the same cycle.
- A small registered stage captures the last result, zero flag and a sticky overflow flag for status and debug.

Parameters:
WIDTH, 32, operand and result width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
clk  input  1  rising-edge clock for the registered status stage
reset  input  1  synchronous, active-high; clears registered outputs
SrcA  input  WIDTH  operand A (rs value)
SrcB  input  WIDTH  operand B (rt value or sign-extended immediate)
ALUControl  input  3  operation select
ALUResult  output  WIDTH  combinational result
zero_flag  output  1  combinational; 1 when ALUResult == 0
overflow  output  1  combinational signed overflow for ADD/SUB; 0 for all other ops
result_q  output  WIDTH  ALUResult registered at each clk edge
zero_q  output  1  zero_flag registered at each clk edge
ovf_sticky  output  1  set when overflow=1 at a clk edge; cleared only by reset

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (port name reset).
- ALUResult, zero_flag and overflow are purely combinational:
  - no latency, valid in the same cycle;
  - independent of clk and reset.
- ALUControl decode:
  - 000 AND: SrcA & SrcB
  - 001 OR: SrcA | SrcB
  - 010 ADD: SrcA + SrcB, carry-out discarded
  - 011 reserved: result 0
  - 100 SUB: SrcA - SrcB, two's complement, wraps
  - 101 MUL: low WIDTH bits of SrcA*SrcB. Signed and unsigned give identical low bits. See optional feature.
  - 110 SLT: 1 if signed SrcA < signed SrcB, else 0; upper bits zero
  - 111 NOR: ~(SrcA | SrcB)
- zero_flag = (ALUResult == 0) for every op, including reserved.
- overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from SrcA.
  - All other ops: 0.
- SLT must not use the subtraction sign alone; it must be correct when SrcA - SrcB overflows (e.g. 0x80000000 < 0x7FFFFFFF gives 1).
- Registered stage, each rising clk edge:
  - reset=1: result_q=0, zero_q=0, ovf_sticky=0.
  - otherwise: result_q<=ALUResult, zero_q<=zero_flag, ovf_sticky<=ovf_sticky | overflow.
- Reset mid-operation clears only the registered outputs; combinational outputs keep following the inputs.
- After the first clock with reset asserted, no X on any output once inputs are known.

Optional Feature:
ALU_MULT_EN
- Defined: ALUControl=101 returns the low WIDTH bits of the product, combinational.
- Undefined: 101 is treated as reserved; ALUResult=0, zero_flag=1, overflow=0. No multiplier logic is synthesized.
- All other opcodes behave identically in both builds.

Test Plan:
- SrcA=0, SrcB=199999 (0x00030D3F) per op:
  - 101 -> 0, zero=1
  - 001 -> 0x00030D3F, zero=0
  - 010 -> 0x00030D3F
  - 100 -> 0xFFFCF2C1, overflow=0
  - 110 -> 1
  - 111 -> 0xFFFCF2C0
  - 000 -> 0, zero=1
- SrcA=1, SrcB=199999, ALUControl=101 -> 0x00030D3F with ALU_MULT_EN; 0 with zero=1 without it.
- SrcA=0x7FFFFFFF, SrcB=1, ADD -> 0x80000000, overflow=1; next clk edge ovf_sticky=1 and stays 1 across later ops until reset.
- SrcA=0x80000000, SrcB=0x7FFFFFFF:
  - SLT -> 1
  - SUB -> 0x00000001, overflow=1
- Assert reset for one edge after activity -> result_q=0, zero_q=0, ovf_sticky=0; ALUResult still tracks the inputs.
- ALUControl=011 with any operands -> ALUResult=0, zero_flag=1; result_q=0 and zero_q=1 after the next edge.
